// File: rtl/ddr4_refresh_scheduler_pkg.sv
// Shared state encoding, default timing constants and helpers for the DDR4
// refresh scheduler and its tREFI timer.
package ddr4_refresh_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_PASS,
    ST_DRAIN,
    ST_PALL,
    ST_WAIT_RP,
    ST_REF,
    ST_WAIT_RFC
  } sched_state_e;

  localparam int unsigned DEF_T_REFI   = 2340;
  localparam int unsigned DEF_T_RP     = 4;
  localparam int unsigned DEF_T_RFC    = 105;
  localparam int unsigned DEF_T_DRAIN  = 8;
  localparam int unsigned DEF_IDLE_THR = 16;
  localparam int unsigned DEF_MAX_OWED = 8;
  localparam int unsigned DEF_CMD_W    = 1024;

  // Maintenance slots are always injected into slot 0 of the 4-slot bus.
  localparam logic [3:0] SLOT0 = 4'b0001;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ddr4_refresh_scheduler_refi_timer.sv
// tREFI interval timer: free-runs while calibrated and enabled, emitting a
// single-cycle tick each time it wraps; cleared whenever refresh is disabled.
module ddr4_refi_timer
  import ddr4_refresh_scheduler_pkg::*;
#(
  parameter int unsigned T_REFI = DEF_T_REFI
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init_done,
  input  logic refresh_en,
  output logic tick
);

  localparam int unsigned CW = (T_REFI > 1) ? $clog2(T_REFI) : 1;

  logic [CW-1:0] cnt;
  logic          run;

  assign run  = init_done & refresh_en;
  assign tick = run && (cnt == CW'(T_REFI - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!refresh_en) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ddr4_refresh_scheduler.sv
// Refresh scheduler: passes user commands through one register stage and
// injects PALL/REF maintenance sequences when refreshes are owed.
module ddr4_refresh_scheduler
  import ddr4_refresh_scheduler_pkg::*;
#(
  parameter int unsigned T_REFI   = DEF_T_REFI,
  parameter int unsigned T_RP     = DEF_T_RP,
  parameter int unsigned T_RFC    = DEF_T_RFC,
  parameter int unsigned T_DRAIN  = DEF_T_DRAIN,
  parameter int unsigned IDLE_THR = DEF_IDLE_THR,
  parameter int unsigned MAX_OWED = DEF_MAX_OWED,
  parameter int unsigned CMD_W    = DEF_CMD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init_done,
  input  logic             refresh_en,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CMD_W-1:0] req_cmd,
  output logic             out_valid,
  output logic [CMD_W-1:0] out_cmd,
  output logic [3:0]       ddr_pre,
  output logic [3:0]       ddr_pall,
  output logic [3:0]       ddr_ref,
  output logic             ref_busy,
  output logic [3:0]       owed,
  output logic             ref_overflow
);

  localparam int unsigned WAIT_MAX = max3(T_DRAIN, T_RP, T_RFC);
  localparam int unsigned WCW      = $clog2(WAIT_MAX + 1);
  localparam int unsigned ICW      = $clog2(IDLE_THR + 1);

  // Reload values are one less than the dwell because the load cycle itself
  // is not counted; WAIT_RP/WAIT_RFC dwell one cycle less than tRP/tRFC.
  localparam logic [WCW-1:0] LD_DRAIN = WCW'(T_DRAIN - 1);
  localparam logic [WCW-1:0] LD_RP    = WCW'(T_RP - 2);
  localparam logic [WCW-1:0] LD_RFC   = WCW'(T_RFC - 2);
  localparam logic [3:0]     OWED_MAX = 4'(MAX_OWED);
  localparam logic [ICW-1:0] IDLE_MAX = ICW'(IDLE_THR);

  sched_state_e   state, state_nx;
  logic [WCW-1:0] wait_cnt, wait_nx;
  logic [ICW-1:0] idle_cnt;
  logic [3:0]     owed_nx;
  logic           tick, fire, leave_pass, ref_dec, ovf_set;

  ddr4_refi_timer #(.T_REFI(T_REFI)) u_refi (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_done  (init_done),
    .refresh_en (refresh_en),
    .tick       (tick)
  );

  assign req_ready  = (state == ST_PASS) && init_done && (owed < OWED_MAX);
  assign fire       = req_valid && req_ready;
  assign leave_pass = (owed >= OWED_MAX) || ((owed != '0) && (idle_cnt >= IDLE_MAX));

  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    ref_dec  = 1'b0;
    unique case (state)
      ST_PASS: if (leave_pass) begin
        state_nx = ST_DRAIN;
        wait_nx  = LD_DRAIN;
      end
      ST_DRAIN: if (wait_cnt == '0) state_nx = ST_PALL;
                else wait_nx = wait_cnt - WCW'(1);
      ST_PALL: begin
        state_nx = ST_WAIT_RP;
        wait_nx  = LD_RP;
      end
      ST_WAIT_RP: if (wait_cnt == '0) begin
        state_nx = ST_REF;
        ref_dec  = 1'b1;
      end else wait_nx = wait_cnt - WCW'(1);
      ST_REF: begin
        state_nx = ST_WAIT_RFC;
        wait_nx  = LD_RFC;
      end
      ST_WAIT_RFC: if (wait_cnt == '0) begin
        if (owed >= OWED_MAX - 4'd1) begin
          state_nx = ST_REF;
          ref_dec  = 1'b1;
        end else begin
          state_nx = ST_PASS;
        end
      end else wait_nx = wait_cnt - WCW'(1);
      default: state_nx = ST_PASS;
    endcase
  end

  // owed is decremented on the edge that enters REF, so it moves together
  // with the registered ddr_ref pulse.
  always_comb begin
    owed_nx = owed;
    ovf_set = 1'b0;
    if (tick && !ref_dec) begin
      if (owed >= OWED_MAX) ovf_set = 1'b1;
      else                  owed_nx = owed + 4'd1;
    end else if (ref_dec && !tick && (owed != '0)) begin
      owed_nx = owed - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_PASS;
      wait_cnt     <= '0;
      idle_cnt     <= '0;
      owed         <= '0;
      ref_overflow <= 1'b0;
      out_valid    <= 1'b0;
      out_cmd      <= '0;
      ddr_pre      <= '0;
      ddr_pall     <= '0;
      ddr_ref      <= '0;
      ref_busy     <= 1'b0;
    end else begin
      state        <= state_nx;
      wait_cnt     <= wait_nx;
      owed         <= owed_nx;
      ref_overflow <= ref_overflow | ovf_set;
      if (req_valid)             idle_cnt <= '0;
      else if (idle_cnt < IDLE_MAX) idle_cnt <= idle_cnt + ICW'(1);
      out_valid    <= fire;
      out_cmd      <= fire ? req_cmd : '0;
      ddr_pre      <= (state_nx == ST_PALL) ? SLOT0 : '0;
      ddr_pall     <= (state_nx == ST_PALL) ? SLOT0 : '0;
      ddr_ref      <= (state_nx == ST_REF)  ? SLOT0 : '0;
      ref_busy     <= (state_nx != ST_PASS);
    end
  end

endmodule

// File: tb/tb_ddr4_refresh_scheduler.sv
// Directed bench for ddr4_refresh_scheduler: idle refresh, forced refresh with
// catch-up, tick/REF collision, overflow, mid-sequence reset, pre-calibration.
module tb_ddr4_refresh_scheduler;

  localparam int unsigned CMD_W = 32;
  localparam int unsigned T_REFI = 20;
  localparam int W_OWED1 = 0, W_PALL = 1, W_REF = 2, W_READY = 3, W_BUSY = 4;

  logic             clk, rst_n, init_done, refresh_en, req_valid, req_ready;
  logic [CMD_W-1:0] req_cmd, out_cmd;
  logic             out_valid, ref_busy, ref_overflow;
  logic [3:0]       ddr_pre, ddr_pall, ddr_ref, owed;

  int n_pass = 0;
  int n_total = 0;
  logic [CMD_W-1:0] sb_q[$];

  ddr4_refresh_scheduler #(
    .T_REFI(T_REFI), .T_RP(4), .T_RFC(105), .T_DRAIN(8),
    .IDLE_THR(16), .MAX_OWED(8), .CMD_W(CMD_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done), .refresh_en(refresh_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .out_valid(out_valid), .out_cmd(out_cmd), .ddr_pre(ddr_pre),
    .ddr_pall(ddr_pall), .ddr_ref(ddr_ref), .ref_busy(ref_busy),
    .owed(owed), .ref_overflow(ref_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic bit hit(input int sel);
    case (sel)
      W_OWED1: return owed == 4'd1;
      W_PALL:  return ddr_pall == 4'b0001;
      W_REF:   return ddr_ref == 4'b0001;
      W_READY: return req_ready == 1'b1;
      default: return ref_busy == 1'b1;
    endcase
  endfunction

  task automatic wait_ev(input int sel, input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!hit(sel) && cyc < limit);
  endtask

  task automatic do_reset(input logic idn, input logic ren, input logic rv);
    @(negedge clk);
    rst_n = 1'b0; init_done = 1'b0; refresh_en = 1'b0; req_valid = 1'b0; req_cmd = '0;
    repeat (2) @(negedge clk);
    init_done = idn; refresh_en = ren; req_valid = rv; req_cmd = CMD_W'($urandom);
    rst_n = 1'b1;
  endtask

  task automatic force_ticks(input int n);
    @(negedge clk);
    force dut.tick = 1'b1;
    repeat (n) @(negedge clk);
    release dut.tick;
  endtask

  // Scoreboard: a granted command must appear on out_cmd one cycle later.
  always @(posedge clk) begin
    logic             fire_now, exp_v;
    logic [CMD_W-1:0] exp_cmd;
    fire_now = rst_n && req_valid && req_ready;
    if (fire_now) sb_q.push_back(req_cmd);
    #1;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      exp_v = (sb_q.size() > 0);
      exp_cmd = exp_v ? sb_q.pop_front() : '0;
      chk("sb_out_valid", 64'(out_valid), 64'(exp_v));
      chk("sb_out_cmd", 64'(out_cmd), 64'(exp_cmd));
      chk("user_vs_maint", 64'(out_valid && (|{ddr_pre, ddr_pall, ddr_ref})), 64'd0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, nref, nrdy, nov;
    rst_n = 1'b0; init_done = 1'b0; refresh_en = 1'b0; req_valid = 1'b0; req_cmd = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_cmd", 64'(out_cmd), 64'd0);
    chk("rst_slots", 64'({ddr_pre, ddr_pall, ddr_ref}), 64'd0);
    chk("rst_busy", 64'(ref_busy), 64'd0);
    chk("rst_owed", 64'(owed), 64'd0);
    chk("rst_ovf", 64'(ref_overflow), 64'd0);

    // Idle requester: one tick, opportunistic refresh.
    init_done = 1'b1; refresh_en = 1'b1; rst_n = 1'b1;
    wait_ev(W_OWED1, 60, cyc);
    chk("t1_tick_period", 64'(cyc), 64'(T_REFI));
    refresh_en = 1'b0;
    wait_ev(W_PALL, 60, cyc);
    chk("t1_owed_to_pall", 64'(cyc), 64'd9);
    chk("t1_pre", 64'(ddr_pre), 64'h1);
    chk("t1_ready_busy", 64'(req_ready), 64'd0);
    wait_ev(W_REF, 20, cyc);
    chk("t1_pall_to_ref", 64'(cyc), 64'd4);
    chk("t1_owed_after_ref", 64'(owed), 64'd0);
    wait_ev(W_READY, 200, cyc);
    chk("t1_ref_to_ready", 64'(cyc), 64'd105);
    chk("t1_busy_clear", 64'(ref_busy), 64'd0);

    // Continuous requester: forced refresh at owed=8 with catch-up REF.
    do_reset(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 200 && owed != 4'd8; i++) begin
      @(negedge clk);
      if (owed != 4'd8) req_cmd = CMD_W'($urandom);
    end
    chk("t2_owed_max", 64'(owed), 64'd8);
    chk("t2_ready_drop", 64'(req_ready), 64'd0);
    chk("t2_last_valid", 64'(out_valid), 64'd1);
    chk("t2_last_cmd", 64'(out_cmd), 64'(req_cmd));
    refresh_en = 1'b0;
    wait_ev(W_BUSY, 10, cyc);
    chk("t2_busy_latency", 64'(cyc), 64'd1);
    wait_ev(W_PALL, 40, cyc);
    chk("t2_drain_len", 64'(cyc), 64'd8);
    wait_ev(W_REF, 20, cyc);
    chk("t2_pall_to_ref", 64'(cyc), 64'd4);
    chk("t2_owed_ref1", 64'(owed), 64'd7);
    wait_ev(W_REF, 200, cyc);
    chk("t2_catchup_gap", 64'(cyc), 64'd105);
    chk("t2_owed_ref2", 64'(owed), 64'd6);
    wait_ev(W_READY, 200, cyc);
    chk("t2_ref_to_ready", 64'(cyc), 64'd105);
    chk("t2_no_ovf", 64'(ref_overflow), 64'd0);

    // Tick coinciding with REF at owed=3.
    do_reset(1'b1, 1'b0, 1'b1);
    force_ticks(3);
    chk("t3_owed_pre", 64'(owed), 64'd3);
    req_valid = 1'b0;
    wait_ev(W_PALL, 60, cyc);
    repeat (3) @(negedge clk);
    force dut.tick = 1'b1;
    @(negedge clk);
    release dut.tick;
    chk("t3_ref_issued", 64'(ddr_ref), 64'h1);
    chk("t3_owed_hold", 64'(owed), 64'd3);

    // Nine forced ticks with the timer disabled: saturation and sticky overflow.
    do_reset(1'b1, 1'b0, 1'b1);
    force_ticks(9);
    chk("t4_owed_sat", 64'(owed), 64'd8);
    chk("t4_ovf_set", 64'(ref_overflow), 64'd1);
    chk("t4_busy", 64'(ref_busy), 64'd1);
    wait_ev(W_READY, 400, cyc);
    chk("t4_owed_after", 64'(owed), 64'd6);
    chk("t4_ovf_sticky", 64'(ref_overflow), 64'd1);

    // Reset pulsed during WAIT_RP.
    do_reset(1'b1, 1'b0, 1'b1);
    force_ticks(1);
    req_valid = 1'b0;
    wait_ev(W_PALL, 60, cyc);
    @(negedge clk);
    #2; rst_n = 1'b0; init_done = 1'b0;
    #1;
    chk("t5_outs_zero", 64'({out_valid, ref_busy, ref_overflow, req_ready, owed,
                             ddr_pre, ddr_pall, ddr_ref}), 64'd0);
    chk("t5_cmd_zero", 64'(out_cmd), 64'd0);
    repeat (2) @(negedge clk);
    init_done = 1'b1; rst_n = 1'b1;
    nref = 0;
    repeat (12) begin
      @(negedge clk);
      if (ddr_ref != 4'd0) nref++;
    end
    chk("t5_no_ref", 64'(nref), 64'd0);
    chk("t5_pass_busy", 64'(ref_busy), 64'd0);
    chk("t5_pass_ready", 64'(req_ready), 64'd1);

    // Not calibrated: nothing granted, timer frozen.
    do_reset(1'b0, 1'b1, 1'b1);
    nrdy = 0; nov = 0;
    repeat (T_REFI + 5) begin
      @(negedge clk);
      if (req_ready) nrdy++;
      if (out_valid) nov++;
    end
    chk("t6_ready_count", 64'(nrdy), 64'd0);
    chk("t6_out_valid_count", 64'(nov), 64'd0);
    chk("t6_owed", 64'(owed), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
